// File: rtl/clock_adjust_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// clock_adjust_pkg : shared FSM encoding and width derivations | rev 1.0
// ---------------------------------------------------------------------------
package clock_adjust_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  // One spare bit above the averaged period so a full-scale target can be exceeded.
  function automatic int calc_dw(input int w, input int avg_log2);
    return w + avg_log2 + 1;
  endfunction

  function automatic int calc_adj_init(input int w);
    return 1 << (w - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_adjust_ch.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// clock_adjust_ch : one ring-oscillator trim channel | rev 1.0
// ---------------------------------------------------------------------------
module clock_adjust_ch
  import clock_adjust_pkg::*;
#(
  parameter  int W        = 8,
  parameter  int AVG_LOG2 = 0,
  parameter  int TOL      = 1,
  parameter  int LOCK_N   = 4,
  localparam int DW       = calc_dw(W, AVG_LOG2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [W-1:0]  set_period,
  input  logic          ring,
  output logic [W-1:0]  adj,
  output logic          increment,
  output logic          decrement,
  output logic [DW-1:0] duration,
  output logic          psi
);

  localparam int c_tw = W + AVG_LOG2;
  localparam int c_cw = DW + 1;
  localparam int c_ew = AVG_LOG2 + 1;
  localparam int c_lw = $clog2(LOCK_N + 1);

  localparam logic [W-1:0]    ADJ_INIT    = W'(calc_adj_init(W));
  localparam logic [DW-1:0]   c_cnt_max   = '1;
  localparam logic [c_ew-1:0] c_ecnt_last = c_ew'((1 << AVG_LOG2) - 1);
  localparam logic [c_lw-1:0] c_lock_n    = c_lw'(LOCK_N);
  localparam logic [c_cw-1:0] c_tol       = c_cw'(TOL);

  state_e            state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic              prev_q, prev_d, rise_q, rise_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic [c_ew-1:0]   ecnt_q, ecnt_d;
  logic [c_tw-1:0]   tgt_q, tgt_d;
  logic [DW-1:0]     dur_q, dur_d;
  logic              done_q, done_d;
  logic [W-1:0]      adj_q, adj_d;
  logic              inc_q, inc_d, dec_q, dec_d;
  logic [c_lw-1:0]   lock_q, lock_d;

  logic              w_last_edge, w_ovf, w_meas_end;
  logic [c_cw-1:0]   w_dur_ext, w_tgt_ext, w_hi, w_lo;
  logic              w_too_long, w_too_short;

  // Overflow only counts when no ending edge arrives; both report cnt_q anyway.
  assign w_last_edge = (state_q == ST_MEASURE) && rise_q && (ecnt_q == c_ecnt_last);
  assign w_ovf       = (state_q == ST_MEASURE) && !w_last_edge && (cnt_q == c_cnt_max);
  assign w_meas_end  = w_last_edge || w_ovf;

  assign w_dur_ext   = {1'b0, dur_q};
  assign w_tgt_ext   = c_cw'(tgt_q);
  assign w_hi        = w_tgt_ext + c_tol;
  assign w_lo        = (w_tgt_ext > c_tol) ? (w_tgt_ext - c_tol) : '0;
  assign w_too_long  = w_dur_ext > w_hi;
  assign w_too_short = w_dur_ext < w_lo;

  always_comb begin
    sync1_d = ring;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ld) begin
      state_d = ST_ARM;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_ARM:     if (rise_q) state_d = ST_MEASURE;
        ST_MEASURE: if (w_ovf)  state_d = ST_ARM;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // A load discards any measurement ending now and any decision pending from the last one.
  always_comb begin
    cnt_d  = cnt_q;
    ecnt_d = ecnt_q;
    tgt_d  = tgt_q;
    dur_d  = dur_q;
    done_d = 1'b0;
    adj_d  = adj_q;
    inc_d  = 1'b0;
    dec_d  = 1'b0;
    lock_d = lock_q;
    if (ld) begin
      tgt_d  = c_tw'(set_period) << AVG_LOG2;
      lock_d = '0;
    end else begin
      case (state_q)
        ST_ARM: begin
          if (rise_q) begin
            cnt_d  = DW'(1);
            ecnt_d = '0;
          end
        end
        ST_MEASURE: begin
          if (w_meas_end) begin
            dur_d  = cnt_q;
            done_d = 1'b1;
            cnt_d  = DW'(1);
            ecnt_d = '0;
          end else begin
            cnt_d = cnt_q + DW'(1);
            if (rise_q) ecnt_d = ecnt_q + c_ew'(1);
          end
        end
        default: begin
        end
      endcase

      if (done_q) begin
        if (w_too_long) begin
          lock_d = '0;
          if (adj_q != '1) begin
            adj_d = adj_q + W'(1);
            inc_d = 1'b1;
          end
        end else if (w_too_short) begin
          lock_d = '0;
          if (adj_q != '0) begin
            adj_d = adj_q - W'(1);
            dec_d = 1'b1;
          end
        end else if (lock_q != c_lock_n) begin
          lock_d = lock_q + c_lw'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
      ecnt_q  <= '0;
      tgt_q   <= '0;
      dur_q   <= '0;
      done_q  <= 1'b0;
      adj_q   <= ADJ_INIT;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      lock_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
      ecnt_q  <= ecnt_d;
      tgt_q   <= tgt_d;
      dur_q   <= dur_d;
      done_q  <= done_d;
      adj_q   <= adj_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      lock_q  <= lock_d;
    end
  end

  assign adj       = adj_q;
  assign increment = inc_q;
  assign decrement = dec_q;
  assign duration  = dur_q;
  assign psi       = (lock_q == c_lock_n);

endmodule
`default_nettype wire

// File: rtl/clock_adjust_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// clock_adjust_mc : N independent ring-oscillator trim channels | rev 1.0
// ---------------------------------------------------------------------------
module clock_adjust_mc
  import clock_adjust_pkg::*;
#(
  parameter  int N        = 2,
  parameter  int W        = 8,
  parameter  int AVG_LOG2 = 0,
  parameter  int TOL      = 1,
  parameter  int LOCK_N   = 4,
  localparam int DW       = calc_dw(W, AVG_LOG2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    ld,
  input  logic [W-1:0]    setPeriod,
  input  logic [N-1:0]    ring,
  output logic [N*W-1:0]  adj,
  output logic [N-1:0]    increment,
  output logic [N-1:0]    decrement,
  output logic [N*DW-1:0] duration,
  output logic [N-1:0]    PSI
);

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    clock_adjust_ch #(
      .W        (W),
      .AVG_LOG2 (AVG_LOG2),
      .TOL      (TOL),
      .LOCK_N   (LOCK_N)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .ld         (ld[gi]),
      .set_period (setPeriod),
      .ring       (ring[gi]),
      .adj        (adj[gi*W +: W]),
      .increment  (increment[gi]),
      .decrement  (decrement[gi]),
      .duration   (duration[gi*DW +: DW]),
      .psi        (PSI[gi])
    );
  end

endmodule
`default_nettype wire

// File: doc/clock_adjust_mc.md
CLOCK_ADJUST_MC -- requirements
Module: clock_adjust_mc

Interface
REQ-001 SHALL have parameters: N, default 2, channel count; W, default 8, period and adjust-word width; AVG_LOG2, default 0, averages 2^AVG_LOG2 ring periods per measurement; TOL, default 1, lock tolerance in clk cycles; LOCK_N, default 4, consecutive in-tolerance results needed for lock.
REQ-002 SHALL derive DW = W+AVG_LOG2+1 and ADJ_INIT = 2^(W-1).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ld  input  N  per-channel one-cycle load strobe for the target period.
REQ-006 setPeriod  input  W  shared target period in clk cycles; sampled when ld[i]=1.
REQ-007 ring  input  N  per-channel ring-oscillator outputs, asynchronous to clk.
REQ-008 adj  output  N*W  per-channel oscillator control word; channel i occupies bits [i*W +: W].
REQ-009 increment  output  N  one-cycle pulse when adj[i] is incremented.
REQ-010 decrement  output  N  one-cycle pulse when adj[i] is decremented.
REQ-011 duration  output  N*DW  last completed measurement per channel, in clk cycles.
REQ-012 PSI  output  N  per-channel lock indicator.

Function
REQ-013 Each channel SHALL pass ring[i] through a 2-flop synchronizer and then a rising-edge detector; a detected edge is a one-cycle pulse 3 clk edges after the ring rise.
REQ-014 The per-channel FSM SHALL have the states IDLE, ARM and MEASURE; it leaves IDLE only on ld[i].
REQ-015 On ld[i]: target <= setPeriod<<AVG_LOG2, lock count <= 0, PSI[i] <= 0, state <= ARM, adj[i] unchanged; this applies in any state.
REQ-016 ARM: on the first detected edge, counter <= 1 and edge count <= 0, state <= MEASURE.
REQ-017 MEASURE: the counter SHALL increment every clk; on the 2^AVG_LOG2-th detected edge, duration[i] <= counter, and in the same cycle counter <= 1 and edge count <= 0, so that no ring edge is lost between measurements.
REQ-018 The decision SHALL be registered one cycle after duration updates.
  - duration > target+TOL: adj+1, pulse increment.
  - duration < target-TOL: adj-1, pulse decrement; target-TOL is clamped at 0 and never wraps.
  - Otherwise: no change, lock count +1 (saturating at LOCK_N).
  - Any out-of-tolerance result SHALL clear the lock count and PSI[i].
REQ-019 PSI[i] SHALL be 1 while lock count = LOCK_N.
REQ-020 adj SHALL saturate at 0 and 2^W-1. A suppressed step produces no pulse, and the lock count is still cleared.
REQ-021 If the counter reaches 2^DW-1 in MEASURE (no edge): duration <= 2^DW-1, treated as too long (REQ-018), state <= ARM.
REQ-022 If ld[i] and a measurement-ending edge occur in the same cycle, ld SHALL win: duration is not updated and no decision or pulse is issued.
REQ-023 increment[i] and decrement[i] SHALL never be 1 in the same cycle.
REQ-024 Channels SHALL be fully independent; activity on one channel never affects another.

Reset
REQ-025 While rst=0, every channel SHALL immediately return to the following values:
  - state IDLE
  - adj = ADJ_INIT
  - duration = 0, counter = 0
  - target = 0, lock count = 0
  - increment = 0, decrement = 0, PSI = 0
  - synchronizer and edge flops = 0
REQ-026 Reset asserted mid-measurement SHALL discard the measurement. After release, a channel SHALL stay in IDLE until its ld.

Structure
REQ-027 The FSM state encoding and the ADJ_INIT and DW derivations SHALL live in the shared package clock_adjust_pkg.
REQ-028 A sub-module clock_adjust_ch SHALL hold one channel (synchronizer, FSM, counter, decision, adj, lock); the top SHALL instantiate it N times via generate.

Verification
REQ-029 Common setup for the scenarios below: clk period 40 ns, W=8, AVG_LOG2=0, TOL=1, LOCK_N=4.
REQ-030 The bench SHALL cover these directed scenarios:
  - ring0 period 400 ns (10 clk), setPeriod=10, ld pulse -> duration=10, no pulses, PSI[0]=1 after 4th measurement, adj=128.
  - ring0 period 600 ns (15 clk), setPeriod=10 -> increment pulse each measurement, adj 128->129->130..., PSI[0]=0.
  - ring0 period 200 ns, setPeriod=10, adj forced down to 0 -> decrement pulses stop at adj=0, no wrap to 255.
  - ring0 held low after arm -> duration=511 at overflow, increment pulse, FSM returns to ARM.
  - rst pulled low mid-MEASURE on ch0 while ch1 locked -> all outputs reset immediately; after release both channels stay idle until ld.
  - ld coincident with a measurement-ending edge -> no increment/decrement, duration unchanged, PSI=0.
